// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the stalling data-memory responder.
// Alignment checking is controlled by MEM_RESPONDER_ALIGN_CHECK_EN (see mem_responder.sv).
package mem_responder_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE    = 2'd0,
    REQ_LEGAL   = 2'd1,
    REQ_ILLEGAL = 2'd2
  } req_kind_e;

  // Classifies the strobes seen in IDLE; align_ok is forced high when checking is off.
  function automatic req_kind_e classify_req(logic rd, logic wr, logic align_ok);
    if (!rd && !wr)              return REQ_NONE;
    else if ((rd ^ wr) && align_ok) return REQ_LEGAL;
    else                          return REQ_ILLEGAL;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Memory-stage request/response bundle between the CPU datapath (master) and the responder (slave).
interface mem_responder_if;
  import mem_responder_pkg::*;

  // Handshake: the master presents exactly one of rd/wr with addr/data_in. In IDLE the slave
  // raises stall in that same cycle when it accepts; the master then holds until the done pulse.
  // A request seen with stall low was either absent or illegal (err pulses the next cycle).
  // createdump alone in IDLE is acknowledged by a done pulse the next cycle.
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              rd;
  logic              wr;
  logic              createdump;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic              stall;
  logic              err;

  modport master (
    output addr, data_in, rd, wr, createdump,
    input  data_out, done, stall, err
  );

  modport slave (
    input  addr, data_in, rd, wr, createdump,
    output data_out, done, stall, err
  );

endinterface

// File: rtl/mem_responder_array.sv
// Single-port DEPTH_WORDS x 16 storage with registered read, write enable and synchronous clear.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              re_i,
  input  logic              we_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Clear wins over a same-cycle write, so a reset during RESP drops the pending write.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[idx_i] <= wdata_i;
      end
      if (re_i) begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Stalling memory responder: accepts one request in IDLE, stalls LATENCY cycles, pulses done.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to reject odd byte addresses with an err pulse.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 256
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus,
  output state_e         state_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     widx_q, widx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              op_wr_q, op_wr_d;
  logic              err_q, err_d;
  logic              dump_q, dump_d;

  logic              align_ok;
  req_kind_e         req_kind;
  logic              stall_c;
  logic              mem_re, mem_we;
  logic [AW-1:0]     mem_idx;
  logic              unused_addr_bits;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign align_ok = ~bus.addr[0];
`else
  assign align_ok = 1'b1;
`endif

  assign unused_addr_bits = ^{bus.addr[DATA_W-1:AW+1], bus.addr[0]};
  assign req_kind         = classify_req(bus.rd, bus.wr, align_ok);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    err_d   = 1'b0;
    dump_d  = 1'b0;
    stall_c = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    mem_idx = widx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_kind == REQ_LEGAL) begin
          stall_c = 1'b1;
          widx_d  = bus.addr[AW:1];
          wdata_d = bus.data_in;
          op_wr_d = bus.wr;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            // No BUSY cycle: the read must be launched from the live address now.
            state_d = ST_RESP;
            mem_re  = bus.rd;
            mem_idx = bus.addr[AW:1];
          end else begin
            state_d = ST_BUSY;
          end
        end else if (req_kind == REQ_ILLEGAL) begin
          err_d = 1'b1;
        end else if (bus.createdump) begin
          dump_d = 1'b1;
        end
      end
      ST_BUSY: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          state_d = ST_RESP;
          mem_re  = ~op_wr_q;
        end
      end
      ST_RESP: begin
        mem_we  = op_wr_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      err_q   <= 1'b0;
      dump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      err_q   <= err_d;
      dump_q  <= dump_d;
    end
  end

  mem_responder_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .clr_i   (rst),
    .re_i    (mem_re),
    .we_i    (mem_we),
    .idx_i   (mem_idx),
    .wdata_i (wdata_q),
    .rdata_o (bus.data_out)
  );

  assign bus.stall = stall_c;
  assign bus.done  = (state_q == ST_RESP) | dump_q;
  assign bus.err   = err_q;
  assign state_o   = state_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Stalling data-memory responder answering the processor's memory-stage requests (address, write data, read/write strobes, dump request). Each legal request is held off with `stall` for a fixed, parameterised number of cycles, then completed with a one-cycle `done` pulse. Reads return data with that pulse. Word-addressed storage sits behind a byte address. The block lets the CPU datapath be exercised against a non-single-cycle memory before caches exist.

## Interface
- `LATENCY`, default 2: cycles from acceptance to `done`; legal range 1..15.
- `DEPTH_WORDS`, default 256: number of 16-bit words; power of two.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `addr`  in  16  byte address; word index = `addr[log2(DEPTH_WORDS):1]`; upper bits ignored (wrap).
- `data_in`  in  16  write data.
- `rd`  in  1  read request.
- `wr`  in  1  write request.
- `createdump`  in  1  halt/dump request; sampled only in IDLE.
- `data_out`  out  16  read data; valid in the `done` cycle of a read, held until the next read completes.
- `done`  out  1  one-cycle completion pulse.
- `stall`  out  1  requester must hold and wait.
- `err`  out  1  one-cycle illegal-request pulse.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE with a legal request at cycle T:
  - A legal request is `rd ^ wr`, plus alignment-legal when checking is enabled.
  - `addr`, `data_in` and the op are registered at the end of T.
  - The counter loads `LATENCY-1`.
  - Next state is BUSY, or RESP directly when `LATENCY==1`.
- BUSY: the counter decrements each cycle; at 0, go to RESP.
- RESP: `done=1` for exactly one cycle, then return to IDLE.
  - Write: the array is updated at the edge ending RESP.
  - Read: `data_out` is loaded from the array at the edge entering RESP.
- `stall` is combinational:
  - 1 in IDLE when a legal request is present.
  - 1 throughout BUSY.
  - 0 in RESP and otherwise.
- Input changes while BUSY or RESP are ignored; only the captured request completes.
- `rd & wr` in IDLE: no access, no stall, no done; `err=1` in T+1; the block stays in IDLE.
- `createdump` in IDLE with no request: a one-cycle `done` pulse in T+1 acknowledges it; no array change.
- `createdump` together with a legal request: the request takes precedence and the dump is ignored.
- Reset values:
  - state IDLE, counter 0.
  - `done=0`, `err=0`, `data_out=0`.
  - The whole array is cleared to 0.
- Reset mid-operation: any pending write is discarded (not committed); outputs return to reset values the next cycle.

## Timing
- Request in IDLE at T -> `done` at T+`LATENCY`.
- `stall` is high for T..T+`LATENCY`-1 (`LATENCY` cycles) and low at T+`LATENCY`.
- Earliest next acceptance is T+`LATENCY`+1, so back-to-back throughput is one access per `LATENCY`+1 cycles.
- Read-after-write: a read accepted at T+`LATENCY`+1 returns the new data, because the write committed at the end of T+`LATENCY`.
- `err` pulses at T+1; a new request may be accepted at T+1.

## Configuration
- `MEM_RESPONDER_ALIGN_CHECK_EN`:
  - Defined: a request with `addr[0]==1` is illegal and handled like `rd & wr` (no stall, `err` at T+1, no access).
  - Undefined: `addr[0]` is ignored and the access goes to word `addr[...:1]`.

## Structure
- Shared package `mem_responder_pkg` holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - the data width (16);
  - the counter width (4).
- One sub-module `mem_responder_array`: synchronous single-port `DEPTH_WORDS`x16 RAM with registered read, write enable, and synchronous clear.
- FSM, counter, request capture and `stall`/`err`/`done` logic stay in `mem_responder`.

## Test plan
- `LATENCY=2`: write `addr=0x0010` `data_in=0xBEEF` at T, then read `0x0010` at T+3.
  - Write: `stall` high at T and T+1, `done` at T+2.
  - Read: `done` at T+5 with `data_out=0xBEEF`.
- `LATENCY=1`: read `0x0000` just after reset -> `stall` high only at T, `done` at T+1, `data_out=0x0000`.
- `rd=wr=1` at `0x0004` -> `err=1` only at T+1, `stall` stays 0, no `done`; a subsequent read of `0x0004` returns 0x0000.
- With the macro, a read of `addr=0x0003` -> `err` at T+1, no `done`. Without the macro, a write of 0x1234 to `0x0003` followed by a read of `0x0002` returns 0x1234.
- `LATENCY=3`: write 0xAAAA to `0x0020`, assert `rst` at T+1 -> no `done`; after reset, a read of `0x0020` returns 0x0000.
- `DEPTH_WORDS=256`: write 0x5555 to `0x0200` -> a read of `0x0000` returns 0x5555 (wrap); `createdump` alone in IDLE -> `done` at T+1, `stall` 0.
